// File: rtl/data_line_fill_pkg.sv
// Shared definitions for the critical-word-first line fill engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_line_fill_pkg;

    // Geometry of a 64-byte line made of 32-bit words
    localparam int LINE_WORDS = 16;
    localparam int WORD_IDX_W = 4;
    localparam int BEAT_W     = WORD_IDX_W + 1;

    // Line address slices: tag | set index | byte offset
    localparam int TAG_MSB    = 31;
    localparam int TAG_LSB    = 13;
    localparam int INDEX_MSB  = 12;
    localparam int INDEX_LSB  = 6;
    localparam int OFFSET_MSB = 5;
    localparam int OFFSET_LSB = 0;

    // Word select lives in the offset above the byte lanes
    localparam int WORD_MSB    = OFFSET_MSB;
    localparam int WORD_LSB    = OFFSET_LSB + 2;
    localparam int LINE_BASE_W = TAG_MSB - INDEX_LSB + 1;

    typedef enum logic [2:0] {
        FILL_IDLE  = 3'd0,
        FILL_ISSUE = 3'd1,
        FILL_WAIT  = 3'd2,
        FILL_DONE  = 3'd3,
        FILL_ERROR = 3'd4
    } fill_state_e;

endpackage

// File: rtl/data_line_fill_timeout.sv
// Per-beat watchdog: counts cycles spent waiting for one memory beat.
// Latency: expired is combinational from the registered count.
// Backpressure: none; load restarts the count, enable advances it.
module fill_timeout_counter #(
    parameter int TimeoutCycles = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Restart on load, otherwise count waiting cycles and hold at all-ones
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = 8'd0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // The beat gets TimeoutCycles waiting cycles; the next one gives up
    assign expired = enable && (count_q == 8'(TimeoutCycles));

endmodule

// File: rtl/data_line_fill.sv
// Cache line fill: fetches LineWords words critical-word-first, one read outstanding.
// Latency: 2 cycles per beat with a 1-cycle memory, 2*LineWords+2 cycles request to done.
// Backpressure: request held until MemValid/MemError; aborts on error or beat timeout.
module data_line_fill
    import data_line_fill_pkg::*;
#(
    parameter int LineWords     = LINE_WORDS,
    parameter int TimeoutCycles = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill_request,
    input  logic [31:0] fill_address,
    output logic        fill_busy,
    output logic        fill_word_valid,
    output logic [3:0]  fill_word_index,
    output logic [31:0] fill_word_data,
    output logic        fill_critical,
    output logic        fill_done,
    output logic        fill_error,
    output logic        mem_request,
    output logic [31:0] mem_address,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    input  logic        mem_error
);

    localparam logic [2:0] ST_IDLE  = FILL_IDLE;
    localparam logic [2:0] ST_ISSUE = FILL_ISSUE;
    localparam logic [2:0] ST_WAIT  = FILL_WAIT;
    localparam logic [2:0] ST_DONE  = FILL_DONE;
    localparam logic [2:0] ST_ERROR = FILL_ERROR;

    logic [2:0]             state_q,     state_d;
    logic [LINE_BASE_W-1:0] line_base_q, line_base_d;
    logic [WORD_IDX_W-1:0]  start_word_q, start_word_d;
    logic [BEAT_W-1:0]      beat_q,      beat_d;

    logic                   in_issue;
    logic                   in_wait;
    logic                   timeout_expired;
    logic                   beat_ok;
    logic                   beat_bad;
    logic                   last_beat;
    logic [WORD_IDX_W-1:0]  word_idx;

    // Byte-lane bits of the miss address carry no meaning for a line fill
    logic unused_addr_bits;
    assign unused_addr_bits = ^fill_address[WORD_LSB-1:OFFSET_LSB];

    assign in_issue  = (state_q == ST_ISSUE);
    assign in_wait   = (state_q == ST_WAIT);
    // 4-bit add wraps 15 -> 0, giving critical-word-first order
    assign word_idx  = start_word_q + beat_q[WORD_IDX_W-1:0];
    assign last_beat = (beat_q == BEAT_W'(LineWords - 1));
    // Error and timeout both win over a same-cycle data beat
    assign beat_bad  = in_wait && (mem_error || timeout_expired);
    assign beat_ok   = in_wait && mem_valid && !mem_error && !timeout_expired;

    fill_timeout_counter #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (in_issue),
        .enable  (in_wait),
        .expired (timeout_expired)
    );

    // Fill sequencing: latch line on request, alternate issue/wait per beat
    always_comb begin
        state_d      = state_q;
        line_base_d  = line_base_q;
        start_word_d = start_word_q;
        beat_d       = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_request) begin
                    line_base_d  = {fill_address[TAG_MSB:TAG_LSB],
                                    fill_address[INDEX_MSB:INDEX_LSB]};
                    start_word_d = fill_address[WORD_MSB:WORD_LSB];
                    beat_d       = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (beat_bad) begin
                    state_d = ST_ERROR;
                end else if (beat_ok) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and fill context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            line_base_q  <= '0;
            start_word_q <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            line_base_q  <= line_base_d;
            start_word_q <= start_word_d;
            beat_q       <= beat_d;
        end
    end

    // Outputs are decoded from state, so reset drives them all low at once
    assign fill_busy       = (state_q != ST_IDLE);
    assign mem_request     = in_issue || in_wait;
    assign mem_address     = mem_request ? {line_base_q, word_idx, 2'b00} : 32'd0;
    assign fill_word_valid = beat_ok;
    assign fill_word_index = beat_ok ? word_idx : '0;
    assign fill_word_data  = beat_ok ? mem_data : 32'd0;
    assign fill_critical   = beat_ok && (beat_q == '0);
    assign fill_done       = (state_q == ST_DONE);
    assign fill_error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_data_line_fill.sv
// Bench for data_line_fill: behavioural model plus directed fill scenarios.
// Latency: memory model answers one cycle after a request is first seen.
// Backpressure: memory can hold a beat, error it, or answer while idle.
module tb_data_line_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fill_request = 1'b0;
    logic [31:0] fill_address = 32'd0;
    logic        fill_busy;
    logic        fill_word_valid;
    logic [3:0]  fill_word_index;
    logic [31:0] fill_word_data;
    logic        fill_critical;
    logic        fill_done;
    logic        fill_error;
    logic        mem_request;
    logic [31:0] mem_address;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic        mem_error = 1'b0;

    data_line_fill dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fill_request    (fill_request),
        .fill_address    (fill_address),
        .fill_busy       (fill_busy),
        .fill_word_valid (fill_word_valid),
        .fill_word_index (fill_word_index),
        .fill_word_data  (fill_word_data),
        .fill_critical   (fill_critical),
        .fill_done       (fill_done),
        .fill_error      (fill_error),
        .mem_request     (mem_request),
        .mem_address     (mem_address),
        .mem_valid       (mem_valid),
        .mem_data        (mem_data),
        .mem_error       (mem_error)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int req_cyc = 0;

    // Model: what a fill must look like, in words/beats rather than states
    bit        m_busy = 1'b0;
    bit        m_finish = 1'b0;
    logic [25:0] m_base = '0;
    logic [3:0]  m_start = '0;
    int        m_k = 0;
    int        m_quiet = 0;
    bit        m_errseen = 1'b0;

    // Per-scenario observations
    int          n_strobe, n_done, n_err, n_crit, done_cyc, err_cyc, crit_idx;
    int          idx_q[$];
    logic [31:0] addr_q[$];

    // Memory model controls
    int r_wait = 0;
    int r_beat = 0;
    int hold_beat = -1;
    int err_beat = -1;
    bit both_flag = 1'b0;
    bit force_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qidx(input int i);
        return (i < idx_q.size()) ? idx_q[i] : -1;
    endfunction

    function automatic logic [31:0] qaddr(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic compare();
        logic [3:0]  w;
        logic [31:0] a;
        w = 4'((int'(m_start) + m_k) % 16);
        a = {m_base, w, 2'b00};
        if (!rst_n) begin
            chk("reset_flags", 32'({fill_busy, fill_word_valid, fill_critical,
                                    fill_done, fill_error, mem_request}), 32'd0);
            chk("reset_mem_address", mem_address, 32'd0);
            chk("reset_word_index", 32'(fill_word_index), 32'd0);
            chk("reset_word_data", fill_word_data, 32'd0);
            return;
        end
        chk("busy", 32'(fill_busy), 32'(m_busy));
        chk("critical", 32'(fill_critical), 32'(fill_word_valid && (m_k == 0)));
        if (mem_request) chk("mem_address", mem_address, a);
        if (fill_word_valid) begin
            chk("strobe_cause", 32'(mem_valid && !mem_error), 32'd1);
            chk("word_index", 32'(fill_word_index), 32'(w));
            chk("word_data", fill_word_data, a);
            idx_q.push_back(int'(fill_word_index));
            addr_q.push_back(mem_address);
            if (fill_critical) begin
                n_crit++;
                crit_idx = int'(fill_word_index);
            end
            n_strobe++;
            m_k++;
        end
        if (fill_done) begin
            chk("done_after_all_words", 32'(m_k), 32'd16);
            n_done++;
            done_cyc = cyc;
            m_finish = 1'b1;
        end
        if (fill_error) begin
            chk("error_has_cause", 32'(m_errseen || (m_quiet >= 256)), 32'd1);
            n_err++;
            err_cyc = cyc;
            m_finish = 1'b1;
        end
        if (mem_request) begin
            if (mem_error) m_errseen = 1'b1;
            if (mem_valid || mem_error) m_quiet = 0;
            else m_quiet++;
        end
    endtask

    // One clock: model update at the edge, memory drive after it, check mid-cycle
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_n || m_finish) begin
            m_busy   = 1'b0;
            m_finish = 1'b0;
        end else if (!m_busy && fill_request) begin
            m_busy    = 1'b1;
            m_base    = fill_address[31:6];
            m_start   = fill_address[5:2];
            m_k       = 0;
            m_quiet   = 0;
            m_errseen = 1'b0;
        end
        #1;
        mem_valid = 1'b0;
        mem_error = 1'b0;
        mem_data  = 32'd0;
        if (!fill_busy) r_beat = 0;
        if (mem_request) begin
            r_wait++;
            if (r_wait > 1 && r_beat != hold_beat) begin
                if (r_beat == err_beat) begin
                    mem_error = 1'b1;
                    mem_valid = both_flag;
                end else begin
                    mem_valid = 1'b1;
                end
                mem_data = mem_address;
                r_wait = 0;
                r_beat++;
            end
        end else begin
            r_wait = 0;
        end
        if (force_valid) begin
            mem_valid = 1'b1;
            mem_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic start_fill(input logic [31:0] addr);
        n_strobe = 0; n_done = 0; n_err = 0; n_crit = 0;
        done_cyc = -1; err_cyc = -1; crit_idx = -1;
        idx_q.delete();
        addr_q.delete();
        fill_address = addr;
        fill_request = 1'b1;
        req_cyc = cyc;
        step();
        fill_request = 1'b0;
    endtask

    task automatic run_to_end(input int budget);
        int n = 0;
        while ((n_done + n_err) == 0 && n < budget) begin
            step();
            n++;
        end
        chk("fill_terminated", 32'(n_done + n_err), 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("reset_busy", 32'(fill_busy), 32'd0);
        chk("reset_request", 32'(mem_request), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Aligned line, critical word 0
        start_fill(32'h0000_1000);
        run_to_end(100);
        chk("A_strobes", 32'(n_strobe), 32'd16);
        chk("A_done", 32'(n_done), 32'd1);
        chk("A_error", 32'(n_err), 32'd0);
        chk("A_latency", 32'(done_cyc - req_cyc + 1), 32'd34);
        chk("A_first_idx", 32'(qidx(0)), 32'd0);
        chk("A_last_idx", 32'(qidx(15)), 32'd15);
        chk("A_crit_count", 32'(n_crit), 32'd1);
        chk("A_crit_idx", 32'(crit_idx), 32'd0);
        // A request presented during the done pulse must not start a fill
        fill_request = 1'b1;
        step();
        fill_request = 1'b0;
        chk("A_request_in_done_ignored", 32'(fill_busy), 32'd0);
        step();
        chk("A_still_idle", 32'(fill_busy), 32'd0);

        // Critical word 13, wrapping through 15 -> 0
        start_fill(32'h0000_1034);
        run_to_end(100);
        chk("B_addr0", qaddr(0), 32'h0000_1034);
        chk("B_addr1", qaddr(1), 32'h0000_1038);
        chk("B_addr2", qaddr(2), 32'h0000_103C);
        chk("B_addr3", qaddr(3), 32'h0000_1000);
        chk("B_addr15", qaddr(15), 32'h0000_1030);
        chk("B_idx0", 32'(qidx(0)), 32'd13);
        chk("B_idx3", 32'(qidx(3)), 32'd0);
        chk("B_idx15", 32'(qidx(15)), 32'd12);
        chk("B_crit_idx", 32'(crit_idx), 32'd13);
        chk("B_done", 32'(n_done), 32'd1);
        step();

        // Bus error on the fifth beat
        err_beat = 4;
        start_fill(32'h0000_2000);
        run_to_end(100);
        err_beat = -1;
        chk("C_strobes", 32'(n_strobe), 32'd4);
        chk("C_error", 32'(n_err), 32'd1);
        chk("C_done", 32'(n_done), 32'd0);
        step();
        chk("C_busy_after_error", 32'(fill_busy), 32'd0);

        // Beat 0 never answered: watchdog aborts
        hold_beat = 0;
        start_fill(32'h0000_3000);
        run_to_end(400);
        chk("D_error", 32'(n_err), 32'd1);
        chk("D_done", 32'(n_done), 32'd0);
        chk("D_strobes", 32'(n_strobe), 32'd0);
        chk("D_timeout_latency", 32'(err_cyc - req_cyc), 32'd258);
        chk("D_request_dropped", 32'(mem_request), 32'd0);
        step();
        chk("D_idle", 32'(fill_busy), 32'd0);
        hold_beat = -1;

        // Reset while beat 7 is outstanding
        hold_beat = 7;
        start_fill(32'h0000_4020);
        n = 0;
        while (n_strobe < 7 && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        chk("E_beat7_outstanding", 32'(mem_request), 32'd1);
        chk("E_beat7_address", mem_address, 32'h0000_403C);
        rst_n = 1'b0;
        #1;
        chk("E_reset_flags", 32'({fill_busy, fill_word_valid, fill_critical,
                                  fill_done, fill_error, mem_request}), 32'd0);
        chk("E_reset_address", mem_address, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        chk("E_late_valid_no_strobe", 32'(fill_word_valid), 32'd0);
        chk("E_strobes", 32'(n_strobe), 32'd7);
        chk("E_no_done_no_error", 32'(n_done + n_err), 32'd0);
        hold_beat = -1;
        step();
        start_fill(32'h0000_5000);
        run_to_end(100);
        chk("E_refill_done", 32'(n_done), 32'd1);
        chk("E_refill_strobes", 32'(n_strobe), 32'd16);
        step();

        // MemValid and MemError together on beat 0
        err_beat = 0;
        both_flag = 1'b1;
        start_fill(32'h0000_6000);
        run_to_end(100);
        err_beat = -1;
        both_flag = 1'b0;
        chk("F_strobes", 32'(n_strobe), 32'd0);
        chk("F_error", 32'(n_err), 32'd1);
        chk("F_done", 32'(n_done), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
